// File: rtl/conv_engine_param.sv
// Parametrised int8 convolution engine: IFM buffer plus NUM_PE weight banks, self-sequenced window walk,
// NUM_PE parallel 4-lane MACs and per-channel requantisation, emitting one packed pixel per handshake.
module conv_engine_param #(
   parameter int NUM_PE    = 16,
   parameter int IFM_DEPTH = 4096,
   parameter int W_DEPTH   = 1024,
   parameter int ACC_W     = 32,
   parameter int DIM_W     = 8
) (
   input  logic                                          clk,
   input  logic                                          reset_n,
   input  logic                                          wr_en_ifm,
   input  logic                                          wr_en_w,
   input  logic [((NUM_PE > 1) ? $clog2(NUM_PE) : 1)-1:0] wr_bank,
   input  logic [15:0]                                   wr_addr,
   input  logic [31:0]                                   wr_data,
   input  logic                                          start,
   input  logic [3:0]                                    cfg_kernel_w,
   input  logic [1:0]                                    cfg_stride,
   input  logic [DIM_W-1:0]                              cfg_ifm_w,
   input  logic [DIM_W-1:0]                              cfg_ofm_w,
   input  logic [DIM_W-1:0]                              cfg_ofm_h,
   input  logic [7:0]                                    cfg_c_words,
   input  logic [4:0]                                    cfg_shift,
   input  logic [1:0]                                    cfg_act_mode,
   input  logic [7:0]                                    cfg_relu6_max,
   output logic                                          busy,
   output logic                                          done,
   output logic                                          err_cfg,
   output logic                                          ofm_valid,
   input  logic                                          ofm_ready,
   output logic [NUM_PE*8-1:0]                           ofm_data,
   output logic [DIM_W-1:0]                              ofm_x,
   output logic [DIM_W-1:0]                              ofm_y,
   output logic                                          ofm_last
);

   // state   | meaning
   // S_IDLE  | buffers writable, waiting for start
   // S_RUN   | one IFM/weight address per cycle for the current pixel
   // S_FLUSH | two cycles draining read latency and the MAC register
   // S_OUT   | pixel presented, held until ofm_ready
   // S_DONE  | one-cycle done pulse, then back to idle
   typedef enum logic [2:0] {S_IDLE, S_RUN, S_FLUSH, S_OUT, S_DONE} state_t;

   // Buffer depths are powers of two, so truncating the address gives the modulo wrap.
   localparam int IFM_AW = $clog2(IFM_DEPTH);
   localparam int W_AW   = $clog2(W_DEPTH);

   state_t            state_q, state_d;
   logic [3:0]        k_q, k_d;
   logic [1:0]        s_q, s_d;
   logic [DIM_W-1:0]  ifm_w_q, ifm_w_d, ofm_w_q, ofm_w_d, ofm_h_q, ofm_h_d;
   logic [7:0]        cw_q, cw_d;
   logic [4:0]        shift_q, shift_d;
   logic [1:0]        act_q, act_d;
   logic [7:0]        r6max_q, r6max_d;
   logic [DIM_W-1:0]  ox_q, ox_d, oy_q, oy_d;
   logic [3:0]        ky_q, ky_d, kx_q, kx_d;
   logic [7:0]        c_q, c_d;
   logic              flush_q, flush_d;
   logic              err_q, err_d;
   logic              rd_vld_q, rd_vld_d;
   logic              rd_first_q, rd_first_d;
   logic [NUM_PE*8-1:0] ofm_data_q, ofm_data_d;
   logic signed [ACC_W-1:0] acc_q [NUM_PE];
   logic signed [ACC_W-1:0] acc_d [NUM_PE];
   logic signed [ACC_W-1:0] dot [NUM_PE];

   logic [31:0]       ifm_mem [IFM_DEPTH];
   logic [31:0]       w_mem [NUM_PE][W_DEPTH];
   logic [31:0]       ifm_rdata_q;
   logic [31:0]       w_rdata_q [NUM_PE];

   logic [IFM_AW-1:0] iy, ix, ifm_addr;
   logic [W_AW-1:0]   w_addr;
   logic              idle, last_pix;
   logic              unused_ok;

   assign unused_ok = ^wr_addr;
   assign idle      = (state_q == S_IDLE);
   assign last_pix  = (ox_q == ofm_w_q - DIM_W'(1)) && (oy_q == ofm_h_q - DIM_W'(1));

   assign iy       = IFM_AW'(oy_q) * IFM_AW'(s_q) + IFM_AW'(ky_q);
   assign ix       = IFM_AW'(ox_q) * IFM_AW'(s_q) + IFM_AW'(kx_q);
   assign ifm_addr = (iy * IFM_AW'(ifm_w_q) + ix) * IFM_AW'(cw_q) + IFM_AW'(c_q);
   assign w_addr   = (W_AW'(ky_q) * W_AW'(k_q) + W_AW'(kx_q)) * W_AW'(cw_q) + W_AW'(c_q);

   function automatic logic signed [15:0] mul8(input logic signed [7:0] a, input logic signed [7:0] b);
      return a * b;
   endfunction

   function automatic logic [7:0] requant(input logic signed [ACC_W-1:0] acc, input logic [4:0] sh,
                                          input logic [1:0] mode, input logic [7:0] mx);
      logic signed [ACC_W-1:0] r, lo, hi;
      r  = acc >>> sh;
      lo = ACC_W'(-128);
      hi = ACC_W'(127);
      case (mode)
         2'd1: lo = '0;
         2'd2: begin
            lo = '0;
            hi = {{(ACC_W-8){1'b0}}, mx};
         end
         default: ;
      endcase
      if (r < lo)      return lo[7:0];
      else if (r > hi) return hi[7:0];
      else             return r[7:0];
   endfunction

   always_ff @(posedge clk) begin
      if (wr_en_ifm && idle) ifm_mem[wr_addr[IFM_AW-1:0]] <= wr_data;
      ifm_rdata_q <= ifm_mem[ifm_addr];
   end

   always_ff @(posedge clk) begin
      for (int p = 0; p < NUM_PE; p++) begin
         if (wr_en_w && idle && (int'(wr_bank) == p)) w_mem[p][wr_addr[W_AW-1:0]] <= wr_data;
         w_rdata_q[p] <= w_mem[p][w_addr];
      end
   end

   always_comb begin
      for (int p = 0; p < NUM_PE; p++) begin
         dot[p] = '0;
         for (int l = 0; l < 4; l++) begin
            dot[p] = dot[p] + ACC_W'(mul8(ifm_rdata_q[8*l +: 8], w_rdata_q[p][8*l +: 8]));
         end
         acc_d[p] = acc_q[p];
         if (rd_vld_q) acc_d[p] = (rd_first_q ? '0 : acc_q[p]) + dot[p];
      end
   end

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      s_d        = s_q;
      ifm_w_d    = ifm_w_q;
      ofm_w_d    = ofm_w_q;
      ofm_h_d    = ofm_h_q;
      cw_d       = cw_q;
      shift_d    = shift_q;
      act_d      = act_q;
      r6max_d    = r6max_q;
      ox_d       = ox_q;
      oy_d       = oy_q;
      ky_d       = ky_q;
      kx_d       = kx_q;
      c_d        = c_q;
      flush_d    = flush_q;
      err_d      = 1'b0;
      rd_vld_d   = 1'b0;
      rd_first_d = (state_q == S_RUN) && (ky_q == 4'd0) && (kx_q == 4'd0) && (c_q == 8'd0);
      ofm_data_d = ofm_data_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if ((cfg_kernel_w == 4'd0) || (cfg_stride == 2'd0) || (cfg_ofm_w == '0) ||
                   (cfg_ofm_h == '0) || (cfg_c_words == 8'd0)) begin
                  err_d = 1'b1;
               end else begin
                  k_d     = cfg_kernel_w;
                  s_d     = cfg_stride;
                  ifm_w_d = cfg_ifm_w;
                  ofm_w_d = cfg_ofm_w;
                  ofm_h_d = cfg_ofm_h;
                  cw_d    = cfg_c_words;
                  shift_d = cfg_shift;
                  act_d   = cfg_act_mode;
                  r6max_d = cfg_relu6_max;
                  ox_d    = '0;
                  oy_d    = '0;
                  ky_d    = '0;
                  kx_d    = '0;
                  c_d     = '0;
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            rd_vld_d = 1'b1;
            if (c_q != cw_q - 8'd1) begin
               c_d = c_q + 8'd1;
            end else begin
               c_d = '0;
               if (kx_q != k_q - 4'd1) begin
                  kx_d = kx_q + 4'd1;
               end else begin
                  kx_d = '0;
                  if (ky_q != k_q - 4'd1) begin
                     ky_d = ky_q + 4'd1;
                  end else begin
                     ky_d    = '0;
                     flush_d = 1'b0;
                     state_d = S_FLUSH;
                  end
               end
            end
         end
         S_FLUSH: begin
            if (!flush_q) begin
               flush_d = 1'b1;
            end else begin
               // acc_q holds the final sum in the second flush cycle
               for (int p = 0; p < NUM_PE; p++) begin
                  ofm_data_d[8*p +: 8] = requant(acc_q[p], shift_q, act_q, r6max_q);
               end
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            if (ofm_ready) begin
               if (last_pix) begin
                  state_d = S_DONE;
               end else begin
                  if (ox_q == ofm_w_q - DIM_W'(1)) begin
                     ox_d = '0;
                     oy_d = oy_q + DIM_W'(1);
                  end else begin
                     ox_d = ox_q + DIM_W'(1);
                  end
                  state_d = S_RUN;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         k_q        <= '0;
         s_q        <= '0;
         ifm_w_q    <= '0;
         ofm_w_q    <= '0;
         ofm_h_q    <= '0;
         cw_q       <= '0;
         shift_q    <= '0;
         act_q      <= '0;
         r6max_q    <= '0;
         ox_q       <= '0;
         oy_q       <= '0;
         ky_q       <= '0;
         kx_q       <= '0;
         c_q        <= '0;
         flush_q    <= 1'b0;
         err_q      <= 1'b0;
         rd_vld_q   <= 1'b0;
         rd_first_q <= 1'b0;
         ofm_data_q <= '0;
         for (int p = 0; p < NUM_PE; p++) acc_q[p] <= '0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         s_q        <= s_d;
         ifm_w_q    <= ifm_w_d;
         ofm_w_q    <= ofm_w_d;
         ofm_h_q    <= ofm_h_d;
         cw_q       <= cw_d;
         shift_q    <= shift_d;
         act_q      <= act_d;
         r6max_q    <= r6max_d;
         ox_q       <= ox_d;
         oy_q       <= oy_d;
         ky_q       <= ky_d;
         kx_q       <= kx_d;
         c_q        <= c_d;
         flush_q    <= flush_d;
         err_q      <= err_d;
         rd_vld_q   <= rd_vld_d;
         rd_first_q <= rd_first_d;
         ofm_data_q <= ofm_data_d;
         for (int p = 0; p < NUM_PE; p++) acc_q[p] <= acc_d[p];
      end
   end

   assign busy      = (state_q == S_RUN) || (state_q == S_FLUSH) || (state_q == S_OUT);
   assign done      = (state_q == S_DONE);
   assign err_cfg   = err_q;
   assign ofm_valid = (state_q == S_OUT);
   assign ofm_last  = (state_q == S_OUT) && last_pix;
   assign ofm_data  = ofm_data_q;
   assign ofm_x     = ox_q;
   assign ofm_y     = oy_q;

endmodule

// File: tb/tb_conv_engine_param.sv
// Directed bench for conv_engine_param: a behavioural convolution model fills a scoreboard of
// expected pixels at start time; a monitor pops and compares on every output handshake.
module tb_conv_engine_param;
   localparam int NPE = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          wr_en_ifm, wr_en_w;
   logic [3:0]    wr_bank;
   logic [15:0]   wr_addr;
   logic [31:0]   wr_data;
   logic          start;
   logic [3:0]    cfg_kernel_w;
   logic [1:0]    cfg_stride;
   logic [7:0]    cfg_ifm_w, cfg_ofm_w, cfg_ofm_h, cfg_c_words;
   logic [4:0]    cfg_shift;
   logic [1:0]    cfg_act_mode;
   logic [7:0]    cfg_relu6_max;
   logic          busy, done, err_cfg, ofm_valid, ofm_ready, ofm_last;
   logic [NPE*8-1:0] ofm_data;
   logic [7:0]    ofm_x, ofm_y;

   typedef struct {
      logic [NPE*8-1:0] data;
      logic [7:0]       x;
      logic [7:0]       y;
      logic             last;
   } pix_t;

   pix_t        sb[$];
   pix_t        mon_e;
   int          n_cmp = 0;
   int          n_fail = 0;
   int          n_pix = 0;
   logic [31:0] ifm_m [4096];
   logic [31:0] w_m [NPE][1024];

   conv_engine_param dut (
      .clk(clk), .reset_n(reset_n), .wr_en_ifm(wr_en_ifm), .wr_en_w(wr_en_w),
      .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
      .cfg_kernel_w(cfg_kernel_w), .cfg_stride(cfg_stride), .cfg_ifm_w(cfg_ifm_w),
      .cfg_ofm_w(cfg_ofm_w), .cfg_ofm_h(cfg_ofm_h), .cfg_c_words(cfg_c_words),
      .cfg_shift(cfg_shift), .cfg_act_mode(cfg_act_mode), .cfg_relu6_max(cfg_relu6_max),
      .busy(busy), .done(done), .err_cfg(err_cfg), .ofm_valid(ofm_valid), .ofm_ready(ofm_ready),
      .ofm_data(ofm_data), .ofm_x(ofm_x), .ofm_y(ofm_y), .ofm_last(ofm_last)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [NPE*8-1:0] obs, input logic [NPE*8-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rq(input int acc, input int sh, input int mode, input int mx);
      int r, lo, hi, t;
      logic [31:0] tv;
      r  = acc >>> sh;
      lo = -128;
      hi = 127;
      if (mode == 1) lo = 0;
      if (mode == 2) begin
         lo = 0;
         hi = mx;
      end
      t  = (r < lo) ? lo : ((r > hi) ? hi : r);
      tv = t;
      return tv[7:0];
   endfunction

   function automatic logic [NPE*8-1:0] model_pix(input int ox, input int oy, input int k, input int s,
                                                  input int iw, input int cw, input int sh,
                                                  input int mode, input int mx);
      logic [NPE*8-1:0] d;
      logic [31:0]      iv, wv;
      int               acc, ia, wa;
      d = '0;
      for (int p = 0; p < NPE; p++) begin
         acc = 0;
         for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++)
               for (int c = 0; c < cw; c++) begin
                  ia = ((((oy * s + ky) * iw) + (ox * s + kx)) * cw + c) & 4095;
                  wa = ((ky * k + kx) * cw + c) & 1023;
                  iv = ifm_m[ia];
                  wv = w_m[p][wa];
                  for (int l = 0; l < 4; l++)
                     acc += int'($signed(iv[8*l +: 8])) * int'($signed(wv[8*l +: 8]));
               end
         d[8*p +: 8] = rq(acc, sh, mode, mx);
      end
      return d;
   endfunction

   task automatic wr_ifm(input int addr, input logic [31:0] data);
      wr_en_ifm = 1'b1;
      wr_addr   = 16'(addr);
      wr_data   = data;
      tick();
      wr_en_ifm = 1'b0;
      ifm_m[addr & 4095] = data;
   endtask

   task automatic wr_w(input int bank, input int addr, input logic [31:0] data);
      wr_en_w = 1'b1;
      wr_bank = 4'(bank);
      wr_addr = 16'(addr);
      wr_data = data;
      tick();
      wr_en_w = 1'b0;
      w_m[bank][addr & 1023] = data;
   endtask

   task automatic start_pass(input int k, input int s, input int iw, input int ow, input int oh,
                             input int cw, input int sh, input int mode, input int mx);
      pix_t e;
      cfg_kernel_w  = 4'(k);
      cfg_stride    = 2'(s);
      cfg_ifm_w     = 8'(iw);
      cfg_ofm_w     = 8'(ow);
      cfg_ofm_h     = 8'(oh);
      cfg_c_words   = 8'(cw);
      cfg_shift     = 5'(sh);
      cfg_act_mode  = 2'(mode);
      cfg_relu6_max = 8'(mx);
      for (int oy = 0; oy < oh; oy++)
         for (int ox = 0; ox < ow; ox++) begin
            e.data = model_pix(ox, oy, k, s, iw, cw, sh, mode, mx);
            e.x    = 8'(ox);
            e.y    = 8'(oy);
            e.last = (ox == ow - 1) && (oy == oh - 1);
            sb.push_back(e);
         end
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int got;
      got = 0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk);
         #1;
         if (ofm_valid) begin
            got = 1;
            break;
         end
      end
      n_cmp++;
      assert (got === 1) else begin
         n_fail++;
         $error("FAIL %s_valid_timeout: observed=%0d expected=1", tag, got);
      end
   endtask

   task automatic wait_done(input string tag);
      int got;
      got = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1;
            break;
         end
      end
      n_cmp++;
      assert (got === 1) else begin
         n_fail++;
         $error("FAIL %s_done_timeout: observed=%0d expected=1", tag, got);
      end
      if (got == 1) chk({tag, "_busy_at_done"}, NPE*8'(busy), '0);
      chk({tag, "_sb_empty"}, NPE*8'(sb.size()), '0);
      tick();
      chk({tag, "_done_pulse"}, NPE*8'(done), '0);
   endtask

   task automatic requant_case(input string tag, input int mode, input int sh, input int mx,
                               input logic [7:0] exp);
      start_pass(1, 1, 1, 1, 1, 1, sh, mode, mx);
      wait_valid(tag);
      chk(tag, ofm_data, {NPE{exp}});
      wait_done(tag);
   endtask

   always @(negedge clk) begin
      if (reset_n && ofm_valid && ofm_ready) begin
         n_cmp++;
         assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_pixel: observed x=%0d y=%0d expected none", ofm_x, ofm_y);
         end
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("pix_data", ofm_data, mon_e.data);
            chk("pix_x", NPE*8'(ofm_x), NPE*8'(mon_e.x));
            chk("pix_y", NPE*8'(ofm_y), NPE*8'(mon_e.y));
            chk("pix_last", NPE*8'(ofm_last), NPE*8'(mon_e.last));
         end
         n_pix++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, base;
      logic [7:0] wb;
      wr_en_ifm = 0; wr_en_w = 0; wr_bank = 0; wr_addr = 0; wr_data = 0; start = 0;
      cfg_kernel_w = 0; cfg_stride = 0; cfg_ifm_w = 0; cfg_ofm_w = 0; cfg_ofm_h = 0;
      cfg_c_words = 0; cfg_shift = 0; cfg_act_mode = 0; cfg_relu6_max = 0; ofm_ready = 1;
      for (int i = 0; i < 4096; i++) ifm_m[i] = 'x;
      for (int p = 0; p < NPE; p++) for (int i = 0; i < 1024; i++) w_m[p][i] = 'x;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", NPE*8'(busy), '0);
      chk("rst_done", NPE*8'(done), '0);
      chk("rst_err", NPE*8'(err_cfg), '0);
      chk("rst_valid", NPE*8'(ofm_valid), '0);
      chk("rst_last", NPE*8'(ofm_last), '0);
      chk("rst_data", ofm_data, '0);
      chk("rst_x", NPE*8'(ofm_x), '0);
      chk("rst_y", NPE*8'(ofm_y), '0);
      reset_n = 1'b1;
      tick();

      // 1x1 kernel, single pixel: latency and basic MAC
      wr_ifm(0, 32'h02020202);
      for (int p = 0; p < NPE; p++) wr_w(p, 0, 32'h03030303);
      start_pass(1, 1, 1, 1, 1, 1, 0, 0, 127);
      chk("t1_busy", NPE*8'(busy), NPE*8'(1));
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (ofm_valid) break;
      end
      chk("t1_latency", NPE*8'(lat), NPE*8'(3));
      chk("t1_data", ofm_data, {NPE{8'h18}});
      chk("t1_last", NPE*8'(ofm_last), NPE*8'(1));
      wait_done("t1");

      // 3x3, CW=4, 2x2 OFM, ReLU6; writes during busy must be dropped
      for (int i = 0; i < 64; i++) wr_ifm(i, 32'h01010101);
      for (int p = 0; p < NPE; p++) begin
         wb = 8'(p - 8);
         for (int i = 0; i < 36; i++) wr_w(p, i, {4{wb}});
      end
      base = n_pix;
      start_pass(3, 1, 4, 2, 2, 4, 4, 2, 96);
      wr_en_ifm = 1'b1; wr_en_w = 1'b1; wr_bank = 4'd3; wr_addr = 16'd0; wr_data = 32'h7F7F7F7F;
      tick();
      wr_en_ifm = 1'b0; wr_en_w = 1'b0;
      wait_valid("t2");
      chk("t2_ch8", NPE*8'(ofm_data[71:64]), '0);
      chk("t2_ch9", NPE*8'(ofm_data[79:72]), NPE*8'(9));
      chk("t2_ch15", NPE*8'(ofm_data[127:120]), NPE*8'(63));
      wait_done("t2");
      chk("t2_count", NPE*8'(n_pix - base), NPE*8'(4));

      // same pass with backpressure on pixel 1
      ofm_ready = 1'b0;
      base = n_pix;
      start_pass(3, 1, 4, 2, 2, 4, 4, 2, 96);
      wait_valid("t3_p0");
      ofm_ready = 1'b1;
      tick();
      ofm_ready = 1'b0;
      wait_valid("t3_p1");
      for (int i = 0; i < 10; i++) begin
         chk("t3_hold_valid", NPE*8'(ofm_valid), NPE*8'(1));
         chk("t3_hold_data", ofm_data, sb[0].data);
         chk("t3_hold_x", NPE*8'(ofm_x), NPE*8'(1));
         chk("t3_hold_y", NPE*8'(ofm_y), '0);
         tick();
      end
      ofm_ready = 1'b1;
      wait_done("t3");
      chk("t3_count", NPE*8'(n_pix - base), NPE*8'(4));

      // rejected start, then writes (both enables together) still land
      cfg_kernel_w = 4'd1; cfg_stride = 2'd1; cfg_ofm_w = 8'd1; cfg_ofm_h = 8'd1; cfg_c_words = 8'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t5_err", NPE*8'(err_cfg), NPE*8'(1));
      chk("t5_busy", NPE*8'(busy), '0);
      tick();
      chk("t5_err_clr", NPE*8'(err_cfg), '0);
      chk("t5_busy2", NPE*8'(busy), '0);
      wr_en_ifm = 1'b1; wr_en_w = 1'b1; wr_bank = 4'd0; wr_addr = 16'd0; wr_data = 32'h05050505;
      tick();
      wr_en_ifm = 1'b0; wr_en_w = 1'b0;
      ifm_m[0] = 32'h05050505;
      w_m[0][0] = 32'h05050505;
      start_pass(1, 1, 1, 1, 1, 1, 0, 0, 127);
      wait_valid("t5");
      chk("t5_ch0", NPE*8'(ofm_data[7:0]), NPE*8'(8'h64));
      wait_done("t5");

      // requantisation boundaries
      wr_ifm(0, 32'hB5B5B5B5);
      for (int p = 0; p < NPE; p++) wr_w(p, 0, 32'h01010101);
      requant_case("rq_m0_neg", 0, 0, 96, 8'h80);
      requant_case("rq_m1_neg", 1, 0, 96, 8'h00);
      requant_case("rq_m0_floor", 0, 3, 96, 8'hDA);
      wr_ifm(0, 32'h7D7D7D7D);
      for (int p = 0; p < NPE; p++) wr_w(p, 0, 32'h0A0A0A0A);
      requant_case("rq_m1_pos", 1, 0, 96, 8'h7F);
      requant_case("rq_m2_pos", 2, 0, 96, 8'h60);
      requant_case("rq_m3_pos", 3, 0, 96, 8'h7F);

      // asynchronous reset during pixel 2, then a clean pass
      ofm_ready = 1'b1;
      base = n_pix;
      start_pass(3, 1, 4, 2, 2, 4, 4, 2, 96);
      for (int i = 0; i < 500; i++) begin
         tick();
         if (n_pix >= base + 2) break;
      end
      chk("t6_reached", NPE*8'(n_pix - base), NPE*8'(2));
      tick();
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_busy", NPE*8'(busy), '0);
      chk("t6_valid", NPE*8'(ofm_valid), '0);
      chk("t6_done", NPE*8'(done), '0);
      chk("t6_last", NPE*8'(ofm_last), '0);
      chk("t6_data", ofm_data, '0);
      chk("t6_x", NPE*8'(ofm_x), '0);
      chk("t6_y", NPE*8'(ofm_y), '0);
      sb.delete();
      repeat (3) begin
         @(negedge clk);
         chk("t6_no_done", NPE*8'(done), '0);
      end
      reset_n = 1'b1;
      tick();
      base = n_pix;
      start_pass(3, 1, 4, 2, 2, 4, 4, 2, 96);
      wait_done("t6");
      chk("t6_count", NPE*8'(n_pix - base), NPE*8'(4));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
